// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA 640x480@60 timing, sync and window constants shared by the display path
package vga_pkg;

  localparam int VGA_SCREEN_WIDTH = 11;
  localparam int VGA_PIX_DIV      = 4;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_WIN_W = 488;
  localparam int VGA_WIN_H = 280;

  function automatic int span_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_start(int active, int fp);
    return active + fp;
  endfunction

  // The window is centred in the active area; the lookup stage uses the same origin
  function automatic int win_origin(int active, int win);
    return (active - win) / 2;
  endfunction

  localparam int VGA_H_TOTAL  = span_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
  localparam int VGA_V_TOTAL  = span_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);
  localparam int VGA_HS_START = sync_start(VGA_H_ACTIVE, VGA_H_FP);
  localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
  localparam int VGA_VS_START = sync_start(VGA_V_ACTIVE, VGA_V_FP);
  localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;
  localparam int VGA_WX0      = win_origin(VGA_H_ACTIVE, VGA_WIN_W);
  localparam int VGA_WY0      = win_origin(VGA_V_ACTIVE, VGA_WIN_H);

  typedef struct packed {
    logic hsync;
    logic vsync;
  } sync_t;

endpackage

// File: rtl/pixel_ce_gen.sv
// rtl/pixel_ce_gen.sv - divides the system clock into a one-clk pixel enable every PIX_DIV clks
module pixel_ce_gen #(
  parameter int PIX_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_ce
);

  localparam int CW = $clog2(PIX_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(PIX_DIV - 1);

  logic [CW-1:0] div_cnt_q;
  logic [CW-1:0] div_cnt_d;

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign pix_ce = (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA pixel counters, window-relative coordinates and registered sync/colour output
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int SCREEN_WIDTH = VGA_SCREEN_WIDTH,
  parameter int PIX_DIV      = VGA_PIX_DIV,
  parameter int H_ACTIVE     = VGA_H_ACTIVE,
  parameter int H_FP         = VGA_H_FP,
  parameter int H_SYNC       = VGA_H_SYNC,
  parameter int H_BP         = VGA_H_BP,
  parameter int V_ACTIVE     = VGA_V_ACTIVE,
  parameter int V_FP         = VGA_V_FP,
  parameter int V_SYNC       = VGA_V_SYNC,
  parameter int V_BP         = VGA_V_BP,
  parameter int WIN_W        = VGA_WIN_W,
  parameter int WIN_H        = VGA_WIN_H
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [SCREEN_WIDTH-1:0] x,
  output logic [SCREEN_WIDTH-1:0] y,
  input  logic [11:0]             color_in,
  output logic                    pix_ce,
  output logic                    hsync,
  output logic                    vsync,
  output logic [3:0]              vga_r,
  output logic [3:0]              vga_g,
  output logic [3:0]              vga_b,
  output logic                    frame_start
);

  typedef logic [SCREEN_WIDTH-1:0] cnt_t;

  localparam cnt_t H_LAST   = cnt_t'(span_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam cnt_t V_LAST   = cnt_t'(span_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam cnt_t HS_START = cnt_t'(sync_start(H_ACTIVE, H_FP));
  localparam cnt_t HS_END   = cnt_t'(sync_start(H_ACTIVE, H_FP) + H_SYNC);
  localparam cnt_t VS_START = cnt_t'(sync_start(V_ACTIVE, V_FP));
  localparam cnt_t VS_END   = cnt_t'(sync_start(V_ACTIVE, V_FP) + V_SYNC);
  localparam cnt_t WX0      = cnt_t'(win_origin(H_ACTIVE, WIN_W));
  localparam cnt_t WX1      = cnt_t'(win_origin(H_ACTIVE, WIN_W) + WIN_W);
  localparam cnt_t WY0      = cnt_t'(win_origin(V_ACTIVE, WIN_H));
  localparam cnt_t WY1      = cnt_t'(win_origin(V_ACTIVE, WIN_H) + WIN_H);

  cnt_t        hc_q, hc_d;
  cnt_t        vc_q, vc_d;
  cnt_t        x_q, x_d;
  cnt_t        y_q, y_d;
  logic        win_q, win_d;
  sync_t       sync_q, sync_d, sync_raw;
  logic [11:0] rgb_q, rgb_d;

  pixel_ce_gen #(
    .PIX_DIV (PIX_DIV)
  ) u_pixel_ce_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_ce (pix_ce)
  );

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_ce) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  // Mapping from the next count keeps x/y aligned with hc/vc for the whole tick
  always_comb begin
    win_d = (hc_d >= WX0) && (hc_d < WX1) && (vc_d >= WY0) && (vc_d < WY1);
    x_d   = win_d ? hc_d - WX0 : '0;
    y_d   = win_d ? vc_d - WY0 : '0;
  end

  always_comb begin
    sync_raw.hsync = !((hc_q >= HS_START) && (hc_q < HS_END));
    sync_raw.vsync = !((vc_q >= VS_START) && (vc_q < VS_END));
    sync_d         = sync_q;
    rgb_d          = rgb_q;
    if (pix_ce) begin
      sync_d = sync_raw;
      rgb_d  = win_q ? color_in : 12'h000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q   <= '0;
      vc_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      win_q  <= 1'b0;
      sync_q <= '{hsync: 1'b1, vsync: 1'b1};
      rgb_q  <= 12'h000;
    end else begin
      hc_q   <= hc_d;
      vc_q   <= vc_d;
      x_q    <= x_d;
      y_q    <= y_d;
      win_q  <= win_d;
      sync_q <= sync_d;
      rgb_q  <= rgb_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = sync_q.hsync;
  assign vsync       = sync_q.vsync;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign frame_start = pix_ce && (hc_q == '0) && (vc_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen on a reduced 80x30 raster
module tb_vga_timing_gen;

  localparam int PD    = 4;
  localparam int HT    = 80;
  localparam int VT    = 30;
  localparam int FRAME = HT * VT;
  localparam int WX0   = 8;
  localparam int WX1   = 56;
  localparam int WY0   = 4;
  localparam int WY1   = 20;
  localparam int HS0   = 68;
  localparam int HS1   = 76;
  localparam int VS0   = 26;
  localparam int VS1   = 28;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] x, y;
  logic [11:0] color_in;
  logic        pix_ce, hsync, vsync, frame_start;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        pat_mode = 1'b0;
  bit          checking = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          kc = 0;

  always #5 clk = ~clk;

  function automatic logic [11:0] pat(int xx, int yy);
    return 12'((xx * 37 + yy * 5 + 273) & 4095);
  endfunction

  function automatic bit in_win(int h, int v);
    return (h >= WX0) && (h < WX1) && (v >= WY0) && (v < WY1);
  endfunction

  assign color_in = pat_mode ? pat(int'(x), int'(y)) : 12'hABC;

  vga_timing_gen #(
    .SCREEN_WIDTH (11),
    .PIX_DIV      (PD),
    .H_ACTIVE     (64),
    .H_FP         (4),
    .H_SYNC       (8),
    .H_BP         (4),
    .V_ACTIVE     (24),
    .V_FP         (2),
    .V_SYNC       (2),
    .V_BP         (2),
    .WIN_W        (48),
    .WIN_H        (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x           (x),
    .y           (y),
    .color_in    (color_in),
    .pix_ce      (pix_ce),
    .hsync       (hsync),
    .vsync       (vsync),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .frame_start (frame_start)
  );

  // Clock edges seen since reset was released
  always @(posedge clk) kc <= rst_n ? kc + 1 : 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s kc=%0d actual=%0h required=%0h", name, kc, act, exp);
    end
  endtask

  task automatic compare();
    int n, p, h, v, pp, ph, pv, ex, ey;
    logic e_ce, e_hs, e_vs, e_fs;
    logic [11:0] e_rgb;
    if (!rst_n) begin
      e_ce = 0; ex = 0; ey = 0; e_hs = 1; e_vs = 1; e_rgb = 0; e_fs = 0;
    end else begin
      e_ce = (kc % PD) == PD - 1;
      n = kc / PD;
      p = n % FRAME;
      h = p % HT;
      v = p / HT;
      ex = in_win(h, v) ? h - WX0 : 0;
      ey = in_win(h, v) ? v - WY0 : 0;
      e_fs = e_ce && (p == 0);
      if (n == 0) begin
        e_hs = 1; e_vs = 1; e_rgb = 0;
      end else begin
        pp = (n - 1) % FRAME;
        ph = pp % HT;
        pv = pp / HT;
        e_hs = !(ph >= HS0 && ph < HS1);
        e_vs = !(pv >= VS0 && pv < VS1);
        e_rgb = in_win(ph, pv) ? (pat_mode ? pat(ph - WX0, pv - WY0) : 12'hABC) : 12'h000;
      end
    end
    check("pix_ce", pix_ce, e_ce);
    check("x", x, ex);
    check("y", y, ey);
    check("hsync", hsync, e_hs);
    check("vsync", vsync, e_vs);
    check("rgb", {vga_r, vga_g, vga_b}, e_rgb);
    check("frame_start", frame_start, e_fs);
  endtask

  initial begin
    int hs_run, hs_fall, vs_run, fs_last;
    logic hs_prev, vs_prev;
    hs_run = 0; hs_fall = -1; vs_run = 0; fs_last = -1; hs_prev = 1; vs_prev = 1;
    forever begin
      @(negedge clk);
      if (checking) begin
        compare();
        if (!rst_n) begin
          hs_run = 0; hs_fall = -1; vs_run = 0; fs_last = -1; hs_prev = 1; vs_prev = 1;
        end else begin
          if (!hsync) begin
            if (hs_prev) begin
              if (hs_fall >= 0) check("hs_period", kc - hs_fall, HT * PD);
              hs_fall = kc;
            end
            hs_run++;
          end else if (!hs_prev) begin
            check("hs_width", hs_run, (HS1 - HS0) * PD);
            hs_run = 0;
          end
          hs_prev = hsync;
          if (!vsync) begin
            vs_run++;
          end else if (!vs_prev) begin
            check("vs_width", vs_run, (VS1 - VS0) * HT * PD);
            vs_run = 0;
          end
          vs_prev = vsync;
          if (frame_start) begin
            if (fs_last >= 0) check("fs_period", kc - fs_last, FRAME * PD);
            fs_last = kc;
          end
        end
      end
    end
  end

  task automatic at_kc(int target);
    int guard;
    guard = 0;
    while (kc != target && guard < 40000) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (kc != target) begin
      bad++;
      $display("FAIL at_kc timeout actual=%0d required=%0d", kc, target);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pat_mode = 1'b0;
    checking = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b1;

    at_kc(3);
    check("lit_first_ce", pix_ce, 1);
    check("lit_first_fs", frame_start, 1);
    at_kc(4);
    check("lit_ce_width", pix_ce, 0);
    at_kc(275);
    check("lit_hs_before", hsync, 1);
    at_kc(276);
    check("lit_hs_fall", hsync, 0);
    at_kc(1308);
    check("lit_x_left_edge", x, 0);
    at_kc(1312);
    check("lit_x_win0", x, 0);
    check("lit_y_win0", y, 0);
    check("lit_rgb_pre", {vga_r, vga_g, vga_b}, 12'h000);
    at_kc(1316);
    check("lit_x_win1", x, 1);
    check("lit_rgb_first", {vga_r, vga_g, vga_b}, 12'hABC);
    at_kc(6300);
    check("lit_x_last", x, 47);
    check("lit_y_last", y, 15);
    at_kc(6304);
    check("lit_x_right", x, 0);
    check("lit_y_right", y, 0);
    check("lit_rgb_last", {vga_r, vga_g, vga_b}, 12'hABC);
    at_kc(6308);
    check("lit_rgb_after", {vga_r, vga_g, vga_b}, 12'h000);
    at_kc(8323);
    check("lit_vs_before", vsync, 1);
    at_kc(8324);
    check("lit_vs_fall", vsync, 0);
    at_kc(22521);
    check("lit_mid_x", x, 22);
    check("lit_mid_y", y, 6);
    check("lit_mid_rgb", {vga_r, vga_g, vga_b}, 12'hABC);

    #2 rst_n = 1'b0;
    #1;
    check("async_x", x, 0);
    check("async_y", y, 0);
    check("async_ce", pix_ce, 0);
    check("async_hs", hsync, 1);
    check("async_vs", vsync, 1);
    check("async_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    check("async_fs", frame_start, 0);

    repeat (5) @(negedge clk);
    pat_mode = 1'b1;
    #2 rst_n = 1'b1;
    at_kc(3);
    check("lit_restart_fs", frame_start, 1);
    at_kc(1316);
    check("lit_pat_x", x, 1);
    check("lit_pat_rgb", {vga_r, vga_g, vga_b}, 12'h111);
    at_kc(10800);
    checking = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
